// File: rtl/ik_swift_pkg.sv
// ik_swift_pkg: shared types, constants and helpers for the ik_swift iteration controller.
package ik_swift_pkg;
  localparam int NUM_JOINTS = 6;
  localparam int DH_W = 21;
  localparam int FIX_W = 36;
  localparam int Z_W = 18;
  typedef logic [NUM_JOINTS-1:0][DH_W-1:0] dh_vec_t;
  typedef logic [NUM_JOINTS-1:0][FIX_W-1:0] delta_vec_t;
  typedef logic [NUM_JOINTS-1:0][FIX_W-1:0] target_vec_t;
  typedef logic [2:0][Z_W-1:0] z_vec_t;
  typedef enum logic [1:0] {IDLE, CRST, RUN, CHECK} ik_iter_state_t;
  function automatic logic [FIX_W-1:0] sat_abs(input logic [FIX_W-1:0] d);
    return d[FIX_W-1] ? ((d[FIX_W-2:0] == '0) ? {1'b0, {(FIX_W-1){1'b1}}} : -d) : d;
  endfunction
endpackage

// File: rtl/ik_iter_ctrl_if.sv
// ik_iter_ctrl_if: controller-to-core link; master drives the core, slave is the core side.
interface ik_iter_ctrl_if;
  import ik_swift_pkg::*;
  logic core_en;
  logic core_rst;
  z_vec_t core_z;
  logic [NUM_JOINTS-1:0] core_joint_type;
  dh_vec_t core_dh_dyn_in;
  target_vec_t core_target;
  logic core_done;
  dh_vec_t core_dh_dyn_out;
  delta_vec_t core_delta;
  modport master(
    output core_en, core_rst, core_z, core_joint_type, core_dh_dyn_in, core_target,
    input core_done, core_dh_dyn_out, core_delta
  );
  modport slave(
    input core_en, core_rst, core_z, core_joint_type, core_dh_dyn_in, core_target,
    output core_done, core_dh_dyn_out, core_delta
  );
endinterface

// File: rtl/ik_converge_check.sv
// ik_converge_check: asserts o_conv when every joint's saturated |delta| is within tolerance.
module ik_converge_check
  import ik_swift_pkg::*;
(
  input delta_vec_t i_delta,
  input logic [FIX_W-1:0] i_tol,
  output logic o_conv
);
  logic [NUM_JOINTS-1:0] w_ok;
  for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_joint
    assign w_ok[j] = sat_abs(i_delta[j]) <= i_tol;
  end
  assign o_conv = &w_ok;
endmodule

// File: rtl/ik_iter_ctrl.sv
// ik_iter_ctrl: iteration sequencer in front of the ik_swift core with start/busy/done handshake.
// Optional per-iteration watchdog enabled by defining IK_ITER_TIMEOUT_EN.
module ik_iter_ctrl
  import ik_swift_pkg::*;
#(
  parameter int MAX_ITER = 64
`ifdef IK_ITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  input z_vec_t z_in,
  input logic [NUM_JOINTS-1:0] joint_type_in,
  input dh_vec_t dh_init,
  input target_vec_t target_in,
  input logic [FIX_W-1:0] tol,
  output logic busy,
  output logic done,
  output logic converged,
  output logic timed_out,
  output logic [7:0] iter_count,
  output dh_vec_t dh_out,
  ik_iter_ctrl_if.master core
);
  localparam logic [7:0] MAX_I = 8'(MAX_ITER);
  ik_iter_state_t r_state, w_next;
  z_vec_t r_z;
  logic [NUM_JOINTS-1:0] r_jt;
  target_vec_t r_target;
  logic [FIX_W-1:0] r_tol;
  delta_vec_t r_delta;
  logic w_conv, w_finish, w_conv_fin;
  ik_converge_check u_conv (.i_delta(r_delta), .i_tol(r_tol), .o_conv(w_conv));
`ifdef IK_ITER_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic w_to;
  always_ff @(posedge clk) begin
    r_wdog <= (rst || r_state != RUN) ? '0 : r_wdog + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && start)) timed_out <= 1'b0;
    else if (w_to) timed_out <= 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // abort takes priority over every in-flight transition, including a same-cycle core_done
  always_comb begin
    w_next = r_state;
    w_finish = 1'b0;
    w_conv_fin = 1'b0;
`ifdef IK_ITER_TIMEOUT_EN
    w_to = 1'b0;
`endif
    if (r_state != IDLE && abort) begin
      w_next = IDLE;
      w_finish = 1'b1;
    end else begin
      case (r_state)
        IDLE: w_next = start ? CRST : IDLE;
        CRST: w_next = RUN;
        RUN: begin
          if (core.core_done) w_next = CHECK;
`ifdef IK_ITER_TIMEOUT_EN
          else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
            w_next = IDLE;
            w_finish = 1'b1;
            w_to = 1'b1;
          end
`endif
        end
        CHECK: begin
          w_finish = w_conv || iter_count == MAX_I;
          w_conv_fin = w_conv;
          w_next = w_finish ? IDLE : CRST;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      converged <= 1'b0;
      iter_count <= '0;
      dh_out <= '0;
      r_z <= '0;
      r_jt <= '0;
      r_target <= '0;
      r_tol <= '0;
      r_delta <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_z <= z_in;
        r_jt <= joint_type_in;
        r_target <= target_in;
        r_tol <= tol;
        dh_out <= dh_init;
        iter_count <= '0;
        done <= 1'b0;
        converged <= 1'b0;
        busy <= 1'b1;
      end
      if (r_state == RUN && core.core_done) begin
        dh_out <= core.core_dh_dyn_out;
        r_delta <= core.core_delta;
        if (!abort) iter_count <= (iter_count < MAX_I) ? iter_count + 8'd1 : iter_count;
      end
      if (w_finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        converged <= w_conv_fin;
      end
    end
  end
  assign core.core_en = r_state == RUN;
  assign core.core_rst = rst || r_state == CRST;
  assign core.core_z = r_z;
  assign core.core_joint_type = r_jt;
  assign core.core_target = r_target;
  assign core.core_dh_dyn_in = dh_out;
endmodule
